// File: rtl/router_sync_if.sv
// router_sync_if
//   Bundles the router FSM handshake and the three FIFO-side flag groups
//   that router_sync sits between.
//   master : the environment (router FSM plus output FIFOs / read side)
//   slave  : router_sync itself
//   FSM side   : detect_add, data_in[1:0], write_enb_reg -> write_enb[2:0], fifo_full
//   FIFO side  : read_enb_*, empty_*, full_* -> vld_out_*, soft_reset_*
interface router_sync_if;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  modport master (
    output detect_add, data_in, write_enb_reg,
    output read_enb_0, read_enb_1, read_enb_2,
    output empty_0, empty_1, empty_2,
    output full_0, full_1, full_2,
    input  write_enb, fifo_full,
    input  vld_out_0, vld_out_1, vld_out_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2
  );

  modport slave (
    input  detect_add, data_in, write_enb_reg,
    input  read_enb_0, read_enb_1, read_enb_2,
    input  empty_0, empty_1, empty_2,
    input  full_0, full_1, full_2,
    output write_enb, fifo_full,
    output vld_out_0, vld_out_1, vld_out_2,
    output soft_reset_0, soft_reset_1, soft_reset_2
  );
endinterface

// File: rtl/router_sync.sv
// router_sync
//   Address/flow synchroniser between the 1x3 router FSM and its three
//   output FIFOs. Latches the header address during address decode, steers
//   the single FSM write enable to the addressed FIFO, returns that FIFO's
//   full flag, exposes per-port valid, and runs one watchdog per port that
//   soft-resets a FIFO whose data sits unread for TIMEOUT cycles.
//   Ports:
//     clock  : system clock, all state on rising edge
//     resetn : synchronous active-low reset
//     bus    : router_sync_if.slave (FSM handshake + FIFO flags)
//   Parameters:
//     TIMEOUT : consecutive unread-valid edges before a soft reset (2..2**CNT_W)
//     CNT_W   : watchdog counter width
module router_sync #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic          clock,
  input  logic          resetn,
  router_sync_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT - 1);

  logic [1:0]       addr_reg;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       soft_reset;
  logic [2:0]       empty, full, rd, vld;
  logic [2:0]       write_enb_c;
  logic             fifo_full_c;

  assign empty = {bus.empty_2, bus.empty_1, bus.empty_0};
  assign full  = {bus.full_2, bus.full_1, bus.full_0};
  assign rd    = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
  assign vld   = ~empty;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_reg   <= 2'b00;
      soft_reset <= 3'b000;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      if (bus.detect_add) addr_reg <= bus.data_in;
      for (int i = 0; i < 3; i++) begin
        // a pop, or an empty FIFO, breaks the unread run
        if (vld[i] && !rd[i]) begin
          if (cnt[i] == CNT_TC) begin
            cnt[i]        <= '0;
            soft_reset[i] <= 1'b1;
          end else begin
            cnt[i]        <= cnt[i] + 1'b1;
            soft_reset[i] <= 1'b0;
          end
        end else begin
          cnt[i]        <= '0;
          soft_reset[i] <= 1'b0;
        end
      end
    end
  end

  // addr_reg=3 is an invalid destination: no write, no back-pressure
  always_comb begin
    write_enb_c = 3'b000;
    fifo_full_c = 1'b0;
    case (addr_reg)
      2'd0: begin write_enb_c[0] = bus.write_enb_reg; fifo_full_c = full[0]; end
      2'd1: begin write_enb_c[1] = bus.write_enb_reg; fifo_full_c = full[1]; end
      2'd2: begin write_enb_c[2] = bus.write_enb_reg; fifo_full_c = full[2]; end
      default: ;
    endcase
  end

  assign bus.write_enb    = write_enb_c;
  assign bus.fifo_full    = fifo_full_c;
  assign bus.vld_out_0    = vld[0];
  assign bus.vld_out_1    = vld[1];
  assign bus.vld_out_2    = vld[2];
  assign bus.soft_reset_0 = soft_reset[0];
  assign bus.soft_reset_1 = soft_reset[1];
  assign bus.soft_reset_2 = soft_reset[2];

endmodule
